fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front end of the pipeline; produces each instruction/PC pair that the fetch/decode pipeline latch captures on every clock edge.
- Owns the program counter and drives the instruction-memory request/response handshake, with one request outstanding at a time.
- Honours stall from the hazard unit and redirect (taken branch/jump) from execute.
- Inserts NOP bubbles whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP, 32'h00000000, instruction word emitted as a bubble
PC_STEP, 1, PC increment per instruction (word-addressed imem)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  decode stalled; hold ir_out/pc_out/valid_out
redirect  input  1  taken branch/jump; flush and reload PC
redirect_pc  input  32  new PC when redirect=1
imem_req  output  1  request valid
imem_addr  output  32  request address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
ir_out  output  32  instruction to the fetch/decode latch
pc_out  output  32  address of ir_out
valid_out  output  1  ir_out is a real instruction (0 = bubble)

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, req_pc=0, state=FETCH, stale=0, hold buffer cleared.
  - ir_out=NOP, pc_out=0, valid_out=0.
  - imem_req=0 while reset=0.
- States: FETCH (issue request), WAIT (one request in flight), HOLD (response buffered, downstream stalled).
- imem_addr=pc whenever imem_req=1.
- imem_req (combinational) =
  - (state==FETCH && !redirect), or
  - (state==WAIT && imem_rvalid && !stale && !stall && !redirect); this back-to-back issue gives one instruction per cycle with zero-wait memory.
- Request accepted = imem_req && imem_ready. On acceptance: req_pc<=pc, pc<=pc+PC_STEP (32-bit wrap, no overflow flag), state<=WAIT.
- FETCH with imem_ready=0: remain in FETCH; pc unchanged.
- WAIT, imem_rvalid=1, stale=0, redirect=0:
  - stall=0: ir_out<=imem_rdata, pc_out<=req_pc, valid_out<=1. Next state is WAIT if a new request was accepted, else FETCH.
  - stall=1: buffer imem_rdata/req_pc, state<=HOLD; outputs unchanged.
- WAIT, imem_rvalid=1, stale=1: discard response, stale<=0, state<=FETCH.
- HOLD, stall=0: ir_out/pc_out<=buffer, valid_out<=1, state<=FETCH.
- Output register rule:
  - stall=1 and redirect=0: ir_out/pc_out/valid_out hold their values.
  - stall=0 and no instruction delivered this cycle: ir_out<=NOP, valid_out<=0, pc_out unchanged.
- Redirect (priority over stall and over any response):
  - pc<=redirect_pc; ir_out<=NOP; valid_out<=0 at the next edge.
  - HOLD: buffer dropped, state<=FETCH.
  - WAIT with no rvalid that cycle: stale<=1, remain WAIT.
  - WAIT with rvalid that cycle: response discarded, state<=FETCH.
  - No request is issued in a redirect cycle.
- Latency: request accept at edge N; response at edge N+k (k>=1); valid_out rises at that edge if unstalled.
- imem_rdata is sampled only when imem_rvalid=1. imem_rvalid in FETCH or HOLD is a protocol error; ignore it.
- Reset mid-request: in-flight response after reset release is not expected; memory is reset by the same signal.

Test Plan:
- Reset release, zero-wait memory (ready=1, rvalid next cycle, rdata=addr+0x100):
  - Required: imem_addr sequence 0,1,2,3; after one-cycle FETCH startup, pc_out 0,1,2 on consecutive cycles with valid_out=1, ir_out 0x100,0x101,0x102.
- imem_ready low 3 cycles at addr 4:
  - Required: imem_req held with addr 4, pc stays 4, valid_out=0 with ir_out=NOP for those cycles, then addr 4 delivered.
- stall=1 for 2 cycles while addr 5 response arrives:
  - Required: outputs frozen on previous instr; state HOLD; after stall drops, pc_out=5 with valid_out=1 next edge; no request issued while in HOLD.
- redirect to 0x40 while addr 7 is in flight (rvalid 2 cycles later):
  - Required: addr 7 response discarded; next imem_addr=0x40; pc_out=0x40 is the first valid output; valid_out=0 in between.
- redirect and stall together during HOLD:
  - Required: buffer dropped, ir_out=NOP, valid_out=0 next edge, fetch resumes at redirect_pc.
- reset asserted mid-WAIT:
  - Required: immediate ir_out=NOP, valid_out=0, imem_req=0; first request after release has imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the PC, drives a single-outstanding imem
// request, and feeds the fetch/decode latch with instructions or bubbles.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        stale_q, stale_d;
  logic [31:0] buf_ir_q, buf_ir_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        rsp_ok;
  logic        accept;

  // A fresh, wanted response in WAIT; only then can we issue back-to-back.
  assign rsp_ok = (state_q == S_WAIT) && imem_rvalid && !stale_q;

  assign imem_req = reset && !redirect &&
                    ((state_q == S_FETCH) || (rsp_ok && !stall));
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  assign ir_out    = ir_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    stale_d  = stale_q;
    buf_ir_d = buf_ir_q;
    buf_pc_d = buf_pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;

    if (accept) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + PC_STEP;
    end

    if (!stall) begin
      ir_d    = NOP;
      valid_d = 1'b0;
    end

    if (redirect) begin
      pc_d    = redirect_pc;
      ir_d    = NOP;
      valid_d = 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (imem_rvalid) begin
            stale_d = 1'b0;
            state_d = S_FETCH;
          end else begin
            stale_d = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (accept) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid && stale_q) begin
            stale_d = 1'b0;
            state_d = S_FETCH;
          end else if (rsp_ok && !stall) begin
            ir_d     = imem_rdata;
            pc_out_d = req_pc_q;
            valid_d  = 1'b1;
            state_d  = accept ? S_WAIT : S_FETCH;
          end else if (rsp_ok) begin
            buf_ir_d = imem_rdata;
            buf_pc_d = req_pc_q;
            state_d  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ir_d     = buf_ir_q;
            pc_out_d = buf_pc_q;
            valid_d  = 1'b1;
            state_d  = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      stale_q  <= 1'b0;
      buf_ir_q <= '0;
      buf_pc_q <= '0;
      ir_q     <= NOP;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      stale_q  <= stale_d;
      buf_ir_q <= buf_ir_d;
      buf_pc_q <= buf_pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple latency-programmable imem.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int unsigned n_checks;
  int unsigned n_fail;

  int          lat;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        last_req;
  logic [31:0] last_addr;

  fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ir_out     (ir_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle, entered and left at a falling edge. The memory answers
  // rdata=addr+0x100, lat cycles after the accepting edge.
  task automatic step();
    if (mem_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr + 32'h100;
      mem_cnt     = 0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hdead_beef;
      if (mem_cnt > 1) mem_cnt = mem_cnt - 1;
    end
    #1;
    last_req  = imem_req;
    last_addr = imem_addr;
    if (imem_req && imem_ready) begin
      mem_addr = imem_addr;
      mem_cnt  = lat;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (ir_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ir: got %h exp %h", ir_out, 32'h0);
    end
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_pc: got %h exp %h", pc_out, 32'h0);
    end
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b exp 0", valid_out);
    end
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req: got %b exp 0", imem_req);
    end
    reset = 1'b1;
  endtask

  task automatic test_zero_wait();
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL zw_addr0: got %b/%h exp 1/0", last_req, last_addr);
    end
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_startup: got %b exp 0", valid_out);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (last_addr !== 32'(i)) begin
        n_fail++;
        $display("FAIL zw_addr%0d: got %h exp %h", i, last_addr, 32'(i));
      end
      n_checks++;
      if (valid_out !== 1'b1 || pc_out !== 32'(i - 1) ||
          ir_out !== 32'(i - 1) + 32'h100) begin
        n_fail++;
        $display("FAIL zw_out%0d: got %b/%h/%h exp 1/%h/%h", i, valid_out,
                 pc_out, ir_out, 32'(i - 1), 32'(i - 1) + 32'h100);
      end
    end
  endtask

  task automatic test_ready_low();
    imem_ready = 1'b0;
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'd4) begin
      n_fail++;
      $display("FAIL rl_req0: got %b/%h exp 1/4", last_req, last_addr);
    end
    n_checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'd3 || ir_out !== 32'h103) begin
      n_fail++;
      $display("FAIL rl_out3: got %b/%h/%h exp 1/3/103", valid_out, pc_out,
               ir_out);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      n_checks++;
      if (last_req !== 1'b1 || last_addr !== 32'd4) begin
        n_fail++;
        $display("FAIL rl_req%0d: got %b/%h exp 1/4", i, last_req, last_addr);
      end
      n_checks++;
      if (valid_out !== 1'b0 || ir_out !== 32'h0) begin
        n_fail++;
        $display("FAIL rl_bubble%0d: got %b/%h exp 0/0", i, valid_out, ir_out);
      end
    end
    imem_ready = 1'b1;
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'd4 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rl_accept: got %b/%h/%b exp 1/4/0", last_req, last_addr,
               valid_out);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'd4 || ir_out !== 32'h104) begin
      n_fail++;
      $display("FAIL rl_out4: got %b/%h/%h exp 1/4/104", valid_out, pc_out,
               ir_out);
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (last_req !== 1'b0) begin
        n_fail++;
        $display("FAIL st_req%0d: got %b exp 0", i, last_req);
      end
      n_checks++;
      if (valid_out !== 1'b1 || pc_out !== 32'd4 || ir_out !== 32'h104) begin
        n_fail++;
        $display("FAIL st_frozen%0d: got %b/%h/%h exp 1/4/104", i, valid_out,
                 pc_out, ir_out);
      end
    end
    stall = 1'b0;
    step();
    n_checks++;
    if (last_req !== 1'b0) begin
      n_fail++;
      $display("FAIL st_hold_req: got %b exp 0", last_req);
    end
    n_checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'd5 || ir_out !== 32'h105) begin
      n_fail++;
      $display("FAIL st_out5: got %b/%h/%h exp 1/5/105", valid_out, pc_out,
               ir_out);
    end
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'd6 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL st_resume: got %b/%h/%b exp 1/6/0", last_req, last_addr,
               valid_out);
    end
  endtask

  task automatic test_redirect();
    lat = 2;
    step();
    n_checks++;
    if (last_addr !== 32'd7 || valid_out !== 1'b1 || pc_out !== 32'd6) begin
      n_fail++;
      $display("FAIL rd_pre: got %h/%b/%h exp 7/1/6", last_addr, valid_out,
               pc_out);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    n_checks++;
    if (last_req !== 1'b0 || valid_out !== 1'b0 || ir_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_cycle: got %b/%b/%h exp 0/0/0", last_req, valid_out,
               ir_out);
    end
    step();
    n_checks++;
    if (last_req !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_discard: got %b/%b exp 0/0", last_req, valid_out);
    end
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h40 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_newaddr: got %b/%h/%b exp 1/40/0", last_req, last_addr,
               valid_out);
    end
    step();
    n_checks++;
    if (last_req !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_gap: got %b/%b exp 0/0", last_req, valid_out);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h40 || ir_out !== 32'h140) begin
      n_fail++;
      $display("FAIL rd_first: got %b/%h/%h exp 1/40/140", valid_out, pc_out,
               ir_out);
    end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (last_req !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'h40) begin
        n_fail++;
        $display("FAIL rh_frozen%0d: got %b/%b/%h exp 0/1/40", i, last_req,
                 valid_out, pc_out);
      end
    end
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    n_checks++;
    if (last_req !== 1'b0 || valid_out !== 1'b0 || ir_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rh_flush: got %b/%b/%h exp 0/0/0", last_req, valid_out,
               ir_out);
    end
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h80 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rh_newaddr: got %b/%h/%b exp 1/80/0", last_req, last_addr,
               valid_out);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rh_gap: got %b exp 0", valid_out);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h80 || ir_out !== 32'h180) begin
      n_fail++;
      $display("FAIL rh_first: got %b/%h/%h exp 1/80/180", valid_out, pc_out,
               ir_out);
    end
  endtask

  task automatic test_reset_mid();
    lat = 1;
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (ir_out !== 32'h0 || valid_out !== 1'b0 || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_out: got %h/%b/%h exp 0/0/0", ir_out, valid_out,
               pc_out);
    end
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_req: got %b exp 0", imem_req);
    end
    mem_cnt     = 0;
    imem_rvalid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_addr: got %b/%h exp 1/0", last_req, last_addr);
    end
    step();
    n_checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0 || ir_out !== 32'h100) begin
      n_fail++;
      $display("FAIL rm_first: got %b/%h/%h exp 1/0/100", valid_out, pc_out,
               ir_out);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    lat         = 1;
    mem_cnt     = 0;
    mem_addr    = '0;
    last_req    = 1'b0;
    last_addr   = '0;
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    test_reset();
    test_zero_wait();
    test_ready_low();
    test_stall_hold();
    test_redirect();
    test_redirect_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
